// File: rtl/proc_pkg.sv
// Shared types for the processor memory subsystem: word width, arbiter owner
// encoding and the muxed memory request bundle.
package proc_pkg;

    localparam int WORD_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE,
        OWN_D,
        OWN_I
    } arb_owner_e;

    typedef struct packed {
        logic [WORD_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] wdata;
        logic                 read;
        logic                 write;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one variable-latency
// memory; data wins, but a bounded data streak forces a pending fetch through.
module mem_port_arbiter
    import proc_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    parameter int CNT_BITS        = 16
) (
    input  logic                 Clock_i,
    input  logic                 Resetn_i,
    input  logic [WORD_SIZE-1:0] InstrAddr_i,
    input  logic                 InstrReq_i,
    output logic [WORD_SIZE-1:0] InstrIn_o,
    output logic                 InstrWaitreq_o,
    input  logic [WORD_SIZE-1:0] DataAddr_i,
    input  logic [WORD_SIZE-1:0] DataOut_i,
    input  logic                 ReadData_i,
    input  logic                 WriteData_i,
    output logic [WORD_SIZE-1:0] DataIn_o,
    output logic                 DataWaitreq_o,
    output logic [WORD_SIZE-1:0] MemAddr_o,
    output logic [WORD_SIZE-1:0] MemWdata_o,
    output logic                 MemRead_o,
    output logic                 MemWrite_o,
    input  logic [WORD_SIZE-1:0] MemRdata_i,
    input  logic                 MemWaitreq_i,
    output logic [CNT_BITS-1:0]  DataGrants_o,
    output logic [CNT_BITS-1:0]  InstrGrants_o
);

    localparam int                STREAK_W   = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    arb_owner_e           state_q, state_d;
    logic [STREAK_W-1:0]  streak_q, streak_d;
    logic [CNT_BITS-1:0]  dataCnt_q, instrCnt_q;

    logic     dReq;
    logic     pickD, pickI;
    logic     completion, dataDone, instrDone;
    mem_req_t memReq;

    assign dReq = ReadData_i | WriteData_i;

    // A locked owner stays picked only while it still requests, so a dropped
    // request releases the memory strobes in the same cycle.
    always_comb begin
        pickD = 1'b0;
        pickI = 1'b0;
        if (Resetn_i) begin
            case (state_q)
                IDLE: begin
                    if (dReq && InstrReq_i && (streak_q == STREAK_MAX)) pickI = 1'b1;
                    else if (dReq)                                         pickD = 1'b1;
                    else if (InstrReq_i)                                   pickI = 1'b1;
                end
                OWN_D:   pickD = dReq;
                OWN_I:   pickI = InstrReq_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        memReq = '0;
        if (pickD) begin
            memReq.addr  = DataAddr_i;
            memReq.wdata = DataOut_i;
            memReq.read  = ReadData_i;
            memReq.write = WriteData_i & ~ReadData_i;
        end else if (pickI) begin
            memReq.addr = InstrAddr_i;
            memReq.read = 1'b1;
        end
    end

    assign completion = (memReq.read | memReq.write) & ~MemWaitreq_i;
    assign dataDone   = pickD & completion;
    assign instrDone  = pickI & completion;

    assign MemAddr_o      = memReq.addr;
    assign MemWdata_o     = memReq.wdata;
    assign MemRead_o      = memReq.read;
    assign MemWrite_o     = memReq.write;
    assign InstrIn_o      = MemRdata_i;
    assign DataIn_o       = MemRdata_i;
    assign DataWaitreq_o  = ~Resetn_i | (dReq & ~dataDone);
    assign InstrWaitreq_o = ~Resetn_i | (InstrReq_i & ~instrDone);
    assign DataGrants_o   = dataCnt_q;
    assign InstrGrants_o  = instrCnt_q;

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        if (completion) state_d = IDLE;
        else if (pickD) state_d = OWN_D;
        else if (pickI) state_d = OWN_I;
        else            state_d = IDLE;

        if (dataDone) begin
            if (!InstrReq_i)                streak_d = '0;
            else if (streak_q != STREAK_MAX) streak_d = streak_q + STREAK_W'(1);
        end else if (instrDone) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge Clock_i or negedge Resetn_i) begin
        if (!Resetn_i) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            dataCnt_q  <= '0;
            instrCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            dataCnt_q  <= dataCnt_q + CNT_BITS'(dataDone);
            instrCnt_q <= instrCnt_q + CNT_BITS'(instrDone);
        end
    end

`ifndef SYNTHESIS
    a_no_read_and_write: assert property (@(posedge Clock_i) disable iff (!Resetn_i)
        !(ReadData_i && WriteData_i));
    a_data_owner_holds: assert property (@(posedge Clock_i) disable iff (!Resetn_i)
        (state_q == OWN_D) |-> dReq);
    a_instr_owner_holds: assert property (@(posedge Clock_i) disable iff (!Resetn_i)
        (state_q == OWN_I) |-> InstrReq_i);
    a_single_strobe: assert property (@(posedge Clock_i)
        !(MemRead_o && MemWrite_o));
`endif

endmodule
